// File: rtl/sd_access_logger.sv
// sd_access_logger
//   Passive tap on the fake-SD read port. Consecutive word reads are grouped
//   into sector-access bursts. Each closed burst becomes one record in an
//   internal FIFO holding the sector, word count, 16-bit data sum and a
//   partial flag. A valid/ready pop port drains the FIFO.
//
// Ports
//   rdclk, rst_n          clock, asynchronous active-low reset
//   rdreq/rdaddr/rddata   tapped read port (rddata valid one cycle after rdreq)
//   log_valid/log_ready   FIFO head handshake; a pop happens on valid && ready
//   log_sector/len/sum/partial  registered first-word-fall-through head record
//   overflow_cnt          records dropped on a full FIFO (saturating)
//   fifo_level            records currently held
//
// Latency
//   A close is detected in cycle c (a discontinuous request, the 256th word,
//   or the GAP_CYCLES-th idle cycle). The record is written at the end of
//   cycle c+1 and is visible from cycle c+2. With the last rdreq in cycle t,
//   a gap close is therefore visible in cycle t+GAP_CYCLES+2.
module sd_access_logger #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned GAP_CYCLES = 64
) (
  input  logic                  rdclk,
  input  logic                  rst_n,
  input  logic                  rdreq,
  input  logic [39:0]           rdaddr,
  input  logic [15:0]           rddata,
  output logic                  log_valid,
  input  logic                  log_ready,
  output logic [30:0]           log_sector,
  output logic [8:0]            log_len,
  output logic [15:0]           log_sum,
  output logic                  log_partial,
  output logic [15:0]           overflow_cnt,
  output logic [DEPTH_LOG2:0]   fifo_level
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;
  localparam int unsigned IW    = $clog2(GAP_CYCLES + 1);

  typedef struct packed {
    logic [30:0] sector;
    logic [8:0]  len;
    logic [15:0] sum;
    logic        partial;
  } rec_t;

  typedef enum logic {
    S_IDLE,
    S_OPEN
  } state_t;

  // ---------------------------------------------------------------------
  // Request stage
  // ---------------------------------------------------------------------
  state_t        state, state_nxt;
  logic [30:0]   cur_sector;
  logic [8:0]    cur_off;
  logic [8:0]    cur_len;
  logic [39:0]   expect_addr;
  logic          cur_tag;
  logic [IW-1:0] idle_cnt;

  logic          burst_open;
  logic          continue_hit;
  logic          open_new;
  logic          len_full;
  logic          gap_hit;
  logic          close_now;
  logic [8:0]    close_len;
  logic          req_tag;

  always_comb begin
    burst_open   = (state == S_OPEN);
    continue_hit = burst_open && rdreq && (rdaddr == expect_addr) && (rdaddr[8:0] != '0);
    open_new     = rdreq && !continue_hit;
    len_full     = continue_hit && (cur_len == 9'd255);
    gap_hit      = burst_open && !rdreq && (idle_cnt == IW'(GAP_CYCLES - 1));
    close_now    = (burst_open && open_new) || len_full || gap_hit;
    close_len    = len_full ? 9'd256 : cur_len;
    // Each burst toggles the tag so the previous burst's last data word and
    // the new burst's first data word land in different accumulators.
    req_tag      = open_new ? ~cur_tag : cur_tag;
  end

  always_comb begin
    state_nxt = state;
    if (open_new) begin
      state_nxt = S_OPEN;
    end else if (len_full || gap_hit) begin
      state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge rdclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge rdclk or negedge rst_n) begin
    if (!rst_n) begin
      cur_sector  <= '0;
      cur_off     <= '0;
      cur_len     <= '0;
      expect_addr <= '0;
      cur_tag     <= 1'b0;
      idle_cnt    <= '0;
    end else begin
      if (rdreq) begin
        idle_cnt <= '0;
      end else if (idle_cnt != IW'(GAP_CYCLES)) begin
        idle_cnt <= idle_cnt + IW'(1);
      end

      if (open_new) begin
        cur_sector  <= rdaddr[39:9];
        cur_off     <= rdaddr[8:0];
        cur_len     <= 9'd1;
        expect_addr <= rdaddr + 40'd2;
        cur_tag     <= ~cur_tag;
      end else if (continue_hit) begin
        cur_len     <= cur_len + 9'd1;
        expect_addr <= expect_addr + 40'd2;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Data stage: accumulate rddata one cycle after its request
  // ---------------------------------------------------------------------
  logic        req_d;
  logic        tag_d;
  logic        first_d;
  logic [15:0] acc     [2];
  logic [15:0] acc_nxt [2];

  always_comb begin
    acc_nxt = acc;
    if (req_d) begin
      acc_nxt[tag_d] = first_d ? rddata : (acc[tag_d] + rddata);
    end
  end

  always_ff @(posedge rdclk or negedge rst_n) begin
    if (!rst_n) begin
      req_d   <= 1'b0;
      tag_d   <= 1'b0;
      first_d <= 1'b0;
      acc[0]  <= '0;
      acc[1]  <= '0;
    end else begin
      req_d   <= rdreq;
      tag_d   <= req_tag;
      first_d <= open_new;
      acc     <= acc_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Pending record: holds a closed burst for one cycle so that its last
  // data word (at most one cycle behind the close) is folded into the sum.
  // The sum is taken from acc_nxt so a word arriving in this very cycle is
  // included.
  // ---------------------------------------------------------------------
  logic        pend_valid;
  logic [30:0] pend_sector;
  logic [8:0]  pend_len;
  logic        pend_partial;
  logic        pend_tag;
  rec_t        push_rec;

  always_ff @(posedge rdclk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid   <= 1'b0;
      pend_sector  <= '0;
      pend_len     <= '0;
      pend_partial <= 1'b0;
      pend_tag     <= 1'b0;
    end else begin
      pend_valid <= close_now;
      if (close_now) begin
        pend_sector  <= cur_sector;
        pend_len     <= close_len;
        pend_partial <= (close_len != 9'd256) || (cur_off != '0);
        pend_tag     <= cur_tag;
      end
    end
  end

  always_comb begin
    push_rec.sector  = pend_sector;
    push_rec.len     = pend_len;
    push_rec.sum     = acc_nxt[pend_tag];
    push_rec.partial = pend_partial;
  end

  // ---------------------------------------------------------------------
  // Record FIFO with registered first-word-fall-through head
  // ---------------------------------------------------------------------
  rec_t                  mem [DEPTH];
  rec_t                  head;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] rd_nxt;
  logic [LW-1:0]         level;
  logic [LW-1:0]         level_nxt;
  logic                  pop;
  logic                  full;
  logic                  push_ok;
  logic                  drop;

  always_comb begin
    pop       = log_valid && log_ready;
    full      = (level == LW'(DEPTH));
    push_ok   = pend_valid && (!full || pop);
    drop      = pend_valid && full && !pop;
    rd_nxt    = pop ? (rd_ptr + DEPTH_LOG2'(1)) : rd_ptr;
    level_nxt = level + LW'(push_ok) - LW'(pop);
  end

  always_ff @(posedge rdclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      head         <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      log_valid    <= 1'b0;
      overflow_cnt <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_rec;
        wr_ptr      <= wr_ptr + DEPTH_LOG2'(1);
      end
      rd_ptr    <= rd_nxt;
      level     <= level_nxt;
      log_valid <= (level_nxt != '0);
      // The new head slot equals the write slot only when the FIFO was
      // (or is about to become) empty; bypass the memory in that case.
      if (level_nxt != '0) begin
        head <= (push_ok && (wr_ptr == rd_nxt)) ? push_rec : mem[rd_nxt];
      end
      if (drop && (overflow_cnt != 16'hFFFF)) begin
        overflow_cnt <= overflow_cnt + 16'd1;
      end
    end
  end

  assign log_sector  = head.sector;
  assign log_len     = head.len;
  assign log_sum     = head.sum;
  assign log_partial = head.partial;
  assign fifo_level  = level;

endmodule

// File: tb/tb_sd_access_logger.sv
module tb_sd_access_logger;

  localparam int unsigned DL2   = 4;
  localparam int unsigned GAP   = 64;
  localparam int unsigned DEPTH = 1 << DL2;

  logic        rdclk;
  logic        rst_n;
  logic        rdreq;
  logic [39:0] rdaddr;
  logic [15:0] rddata;
  logic        log_valid;
  logic        log_ready;
  logic [30:0] log_sector;
  logic [8:0]  log_len;
  logic [15:0] log_sum;
  logic        log_partial;
  logic [15:0] overflow_cnt;
  logic [DL2:0] fifo_level;

  sd_access_logger #(
    .DEPTH_LOG2 (DL2),
    .GAP_CYCLES (GAP)
  ) dut (
    .rdclk        (rdclk),
    .rst_n        (rst_n),
    .rdreq        (rdreq),
    .rdaddr       (rdaddr),
    .rddata       (rddata),
    .log_valid    (log_valid),
    .log_ready    (log_ready),
    .log_sector   (log_sector),
    .log_len      (log_len),
    .log_sum      (log_sum),
    .log_partial  (log_partial),
    .overflow_cnt (overflow_cnt),
    .fifo_level   (fifo_level)
  );

  initial begin
    rdclk = 1'b0;
    forever #5 rdclk = ~rdclk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // ---------------------------------------------------------------------
  // ROM model: answers each request one cycle later
  // ---------------------------------------------------------------------
  bit rom_ones;

  function automatic logic [15:0] rom(input logic [39:0] a);
    logic [15:0] w;
    w = a[16:1] + 16'h1000;
    return rom_ones ? 16'h0001 : w;
  endfunction

  initial begin : rom_proc
    logic        d_req;
    logic [39:0] d_addr;
    rddata = 16'h0000;
    forever begin
      @(posedge rdclk);
      d_req  = rdreq;
      d_addr = rdaddr;
      #1;
      rddata = d_req ? rom(d_addr) : 16'hDEAD;
    end
  end

  // ---------------------------------------------------------------------
  // Behavioural model: splits a run of consecutive word reads into the
  // records the logger must produce (sector boundary or 256 words ends a
  // record; end of the run ends the last one).
  // ---------------------------------------------------------------------
  typedef struct {
    logic [30:0] sector;
    int          len;
    logic [15:0] sum;
    logic        partial;
  } exp_rec_t;

  exp_rec_t exp_q[$];

  task automatic model_run(input logic [39:0] start, input int n);
    exp_rec_t    r;
    logic [39:0] a;
    logic [8:0]  off;
    bit          open;
    open = 0;
    off  = '0;
    r    = '{sector: '0, len: 0, sum: '0, partial: 1'b0};
    for (int i = 0; i < n; i++) begin
      a = start + 40'(2 * i);
      if (open && (a[8:0] == 9'd0)) begin
        r.partial = (r.len != 256) || (off != 9'd0);
        exp_q.push_back(r);
        open = 0;
      end
      if (!open) begin
        r.sector = a[39:9];
        r.len    = 0;
        r.sum    = '0;
        off      = a[8:0];
        open     = 1;
      end
      r.len++;
      r.sum += rom(a);
      if (r.len == 256) begin
        r.partial = (off != 9'd0);
        exp_q.push_back(r);
        open = 0;
      end
    end
    if (open) begin
      r.partial = (r.len != 256) || (off != 9'd0);
      exp_q.push_back(r);
    end
  endtask

  task automatic drive_run(input logic [39:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge rdclk);
      #1;
      rdreq  = 1'b1;
      rdaddr = start + 40'(2 * i);
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge rdclk);
      #1;
      rdreq = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------
  // Compare process: every popped record against the model queue
  // ---------------------------------------------------------------------
  exp_rec_t cr;

  always @(negedge rdclk) begin
    if (rst_n) begin
      check("valid_vs_level", log_valid, fifo_level != '0);
      if (log_valid && log_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_record: got sector 0x%0h len %0d, expected none",
                   log_sector, log_len);
        end else begin
          cr = exp_q.pop_front();
          check("rec_sector",  log_sector,  cr.sector);
          check("rec_len",     log_len,     cr.len);
          check("rec_sum",     log_sum,     cr.sum);
          check("rec_partial", log_partial, cr.partial);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------
  initial begin : main
    int waited;
    rst_n     = 1'b0;
    rdreq     = 1'b0;
    rdaddr    = '0;
    log_ready = 1'b1;
    rom_ones  = 0;

    repeat (3) @(posedge rdclk);
    #1;
    check("rst_valid",    log_valid,    0);
    check("rst_sector",   log_sector,   0);
    check("rst_len",      log_len,      0);
    check("rst_sum",      log_sum,      0);
    check("rst_partial",  log_partial,  0);
    check("rst_overflow", overflow_cnt, 0);
    check("rst_level",    fifo_level,   0);
    @(negedge rdclk);
    rst_n = 1'b1;
    idle(3);

    // Full sector 0x200..0x3FE, ROM all ones
    rom_ones = 1;
    model_run(40'h200, 256);
    check("pin_fs_sector",  exp_q[$].sector,  1);
    check("pin_fs_len",     exp_q[$].len,     256);
    check("pin_fs_sum",     exp_q[$].sum,     16'h0100);
    check("pin_fs_partial", exp_q[$].partial, 0);
    drive_run(40'h200, 256);
    @(posedge rdclk);
    #1;
    rdreq = 1'b0;
    check("fs_valid_c256", log_valid, 0);
    @(posedge rdclk);
    #1;
    check("fs_valid_c257", log_valid, 1);
    check("fs_level_c257", fifo_level, 1);
    idle(5);
    rom_ones = 0;

    // Back-to-back sectors 0 and 1
    model_run(40'h0, 512);
    check("pin_b2b_count", exp_q.size(), 2);
    check("pin_b2b_sec0",  exp_q[0].sector, 0);
    check("pin_b2b_sec1",  exp_q[1].sector, 1);
    drive_run(40'h0, 512);
    idle(5);

    // Partial read closed by the idle gap; visible at t+GAP+2
    model_run(40'h400, 10);
    check("pin_pr_sector",  exp_q[$].sector,  2);
    check("pin_pr_len",     exp_q[$].len,     10);
    check("pin_pr_sum",     exp_q[$].sum,     16'hB42D);
    check("pin_pr_partial", exp_q[$].partial, 1);
    drive_run(40'h400, 10);
    for (int k = 1; k <= int'(GAP) + 2; k++) begin
      @(posedge rdclk);
      #1;
      rdreq = 1'b0;
      if (k == int'(GAP) + 1) check("pr_valid_early", log_valid, 0);
      if (k == int'(GAP) + 2) check("pr_valid_gap",   log_valid, 1);
    end
    idle(3);

    // Discontinuity 0x600 x4 then 0xA00 x4
    model_run(40'h600, 4);
    model_run(40'hA00, 4);
    check("pin_dc_sec0", exp_q[0].sector, 3);
    check("pin_dc_len0", exp_q[0].len,    4);
    check("pin_dc_par0", exp_q[0].partial, 1);
    check("pin_dc_sec1", exp_q[1].sector, 5);
    check("pin_dc_len1", exp_q[1].len,    4);
    check("pin_dc_par1", exp_q[1].partial, 1);
    drive_run(40'h600, 4);
    drive_run(40'hA00, 4);
    idle(GAP + 4);

    // Overflow: DEPTH+3 single-word reads with the consumer stalled
    log_ready = 1'b0;
    for (int i = 0; i < int'(DEPTH) + 3; i++) begin
      if (i < int'(DEPTH)) model_run((40'(i) + 40'h40) << 9, 1);
      drive_run((40'(i) + 40'h40) << 9, 1);
      idle(GAP + 4);
    end
    check("pin_ov_count", exp_q.size(), DEPTH);
    check("ov_level",    fifo_level,   DEPTH);
    check("ov_count",    overflow_cnt, 3);
    check("ov_valid",    log_valid,    1);
    log_ready = 1'b1;
    waited = 0;
    while (fifo_level != '0 && waited < 100) begin
      @(posedge rdclk);
      #1;
      waited++;
    end
    check("ov_drained_level", fifo_level, 0);
    check("ov_drained_model", exp_q.size(), 0);

    // Reset in the middle of a burst, then one full sector
    drive_run(40'h4000, 100);
    @(posedge rdclk);
    #3;
    rst_n = 1'b0;
    rdreq = 1'b0;
    repeat (3) @(posedge rdclk);
    #1;
    check("mr_valid",    log_valid,    0);
    check("mr_level",    fifo_level,   0);
    check("mr_overflow", overflow_cnt, 0);
    check("mr_sum",      log_sum,      0);
    @(negedge rdclk);
    rst_n = 1'b1;
    idle(2);
    model_run(40'h8000, 256);
    check("pin_mr_sector", exp_q[$].sector, 16'h40);
    check("pin_mr_sum",    exp_q[$].sum,    16'h7F80);
    check("pin_mr_count",  exp_q.size(), 1);
    drive_run(40'h8000, 256);
    idle(10);
    check("mr_overflow_end", overflow_cnt, 0);

    waited = 0;
    while ((exp_q.size() != 0 || fifo_level != '0) && waited < 300) begin
      @(posedge rdclk);
      #1;
      waited++;
    end
    check("end_model_empty", exp_q.size(), 0);
    check("end_fifo_empty",  fifo_level,   0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
